fetch_unit: RTL



---
 rtl/fetch_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: PC register, combinational imem addressing,
// 2-entry skid FIFO toward decode, redirect/flush and misaligned-target halt.
//
// state   | meaning
// --------+-----------------------------------------------------------
// FETCH   | normal fetch; captures into FIFO whenever there is space
// HALT    | misaligned redirect seen; no fetch until aligned redirect
module fetch_unit #(
    parameter int          ADDR_W    = 10,
    parameter int          INSTR_LEN = 32,
    parameter int          PC_W      = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    output logic [ADDR_W-1:0]    o_imem_addr,
    input  logic [INSTR_LEN-1:0] i_imem_data,
    input  logic                 i_redirect_valid,
    input  logic [PC_W-1:0]      i_redirect_pc,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [INSTR_LEN-1:0] o_instr,
    output logic [PC_W-1:0]      o_pc,
    output logic                 o_misaligned
);

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [1:0]           cnt_q, cnt_d;
    logic                 mis_q, mis_d;
    logic [PC_W-1:0]      head_pc_q, head_pc_d;
    logic [INSTR_LEN-1:0] head_instr_q, head_instr_d;
    logic [PC_W-1:0]      tail_pc_q, tail_pc_d;
    logic [INSTR_LEN-1:0] tail_instr_q, tail_instr_d;

    logic pop;
    logic push;
    logic target_aligned;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_FETCH;
            pc_q         <= PC_W'(RESET_PC);
            cnt_q        <= 2'd0;
            mis_q        <= 1'b0;
            head_pc_q    <= '0;
            head_instr_q <= '0;
            tail_pc_q    <= '0;
            tail_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            cnt_q        <= cnt_d;
            mis_q        <= mis_d;
            head_pc_q    <= head_pc_d;
            head_instr_q <= head_instr_d;
            tail_pc_q    <= tail_pc_d;
            tail_instr_q <= tail_instr_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        cnt_d          = cnt_q;
        mis_d          = mis_q;
        head_pc_d      = head_pc_q;
        head_instr_d   = head_instr_q;
        tail_pc_d      = tail_pc_q;
        tail_instr_d   = tail_instr_q;
        push           = 1'b0;
        pop            = (cnt_q != 2'd0) && i_ready;
        target_aligned = (i_redirect_pc[1:0] == 2'b00);

        case (state_q)
            ST_FETCH: begin
                if (i_redirect_valid) begin
                    // flush wins over any handshake in progress
                    cnt_d = 2'd0;
                    if (target_aligned) begin
                        pc_d = i_redirect_pc;
                    end else begin
                        mis_d   = 1'b1;
                        state_d = ST_HALT;
                    end
                end else begin
                    push = (cnt_q != 2'd2) || pop;
                    if (push) begin
                        pc_d = pc_q + PC_W'(4);
                    end
                    case (cnt_q)
                        2'd0: begin
                            head_pc_d    = pc_q;
                            head_instr_d = i_imem_data;
                            cnt_d        = 2'd1;
                        end
                        2'd1: begin
                            if (pop) begin
                                head_pc_d    = pc_q;
                                head_instr_d = i_imem_data;
                            end else begin
                                tail_pc_d    = pc_q;
                                tail_instr_d = i_imem_data;
                                cnt_d        = 2'd2;
                            end
                        end
                        default: begin
                            // full: a capture happens only alongside a pop
                            if (pop) begin
                                head_pc_d    = tail_pc_q;
                                head_instr_d = tail_instr_q;
                                tail_pc_d    = pc_q;
                                tail_instr_d = i_imem_data;
                            end
                        end
                    endcase
                end
            end
            ST_HALT: begin
                cnt_d = 2'd0;
                if (i_redirect_valid && target_aligned) begin
                    pc_d    = i_redirect_pc;
                    mis_d   = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    assign o_imem_addr  = pc_q[ADDR_W+1:2];
    assign o_valid      = (cnt_q != 2'd0);
    assign o_instr      = head_instr_q;
    assign o_pc         = head_pc_q;
    assign o_misaligned = mis_q;

endmodule
